// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared RV32I-subset encodings, ALU/immediate/writeback enums, immediate generator
package cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU} alu_op_e;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_type_e;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;

    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_type_e t);
        case (t)
            IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   return {instr[31:12], 12'b0};
            default: return {{20{instr[31]}}, instr[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/cpu_data_path.sv
// rtl/cpu_data_path.sv - PC, fetch, register file, ALU, data memory; CPU_RF_INDEX_INIT_EN selects x[i]=i reset preload
module data_path
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_WORDS = 256
) (
    input  logic      i_clk,
    input  logic      i_reset,
    input  logic      i_reg_we,
    input  logic      i_mem_we,
    input  logic      i_alu_src_imm,
    input  alu_op_e   i_alu_op,
    input  imm_type_e i_imm_type,
    input  wb_sel_e   i_wb_sel,
    input  logic      i_branch,
    input  logic      i_branch_ne,
    input  logic      i_jal,
    output logic [6:0] o_opcode,
    output logic [2:0] o_funct3,
    output logic [6:0] o_funct7
);
    localparam int DA = $clog2(DMEM_WORDS);
    localparam logic [DATA_WIDTH-3:0] DMEM_LIMIT = (DATA_WIDTH-2)'(DMEM_WORDS);

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] rf [0:31];
    logic [DATA_WIDTH-1:0] data_mem [0:DMEM_WORDS-1];

    logic [31:0]           w_instr;
    logic [4:0]            w_rs1, w_rs2, w_rd;
    logic [DATA_WIDTH-1:0] w_imm, w_rs1_data, w_rs2_data, w_op_b, w_alu, w_mem_rdata, w_wb_data;
    logic [DATA_WIDTH-1:0] w_pc_plus4, w_pc_next;
    logic                  w_dmem_hit, w_taken, w_unused_ok;

    instruction_fetch #(.DATA_WIDTH(DATA_WIDTH), .IMEM_BYTES(IMEM_BYTES)) instruction_fetch (
        .i_clk       (i_clk),
        .i_load_en   (1'b0),
        .i_load_addr ('0),
        .i_load_data (32'h0),
        .i_pc        (r_pc),
        .o_instr     (w_instr)
    );

    assign o_opcode = w_instr[6:0];
    assign o_funct3 = w_instr[14:12];
    assign o_funct7 = w_instr[31:25];
    assign w_rd     = w_instr[11:7];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_imm    = imm_gen(w_instr, i_imm_type);

    assign w_rs1_data = (w_rs1 == 5'd0) ? '0 : rf[w_rs1];
    assign w_rs2_data = (w_rs2 == 5'd0) ? '0 : rf[w_rs2];
    assign w_op_b     = i_alu_src_imm ? w_imm : w_rs2_data;

    always_comb begin
        w_alu = w_rs1_data + w_op_b;
        case (i_alu_op)
            ALU_SUB:  w_alu = w_rs1_data - w_op_b;
            ALU_AND:  w_alu = w_rs1_data & w_op_b;
            ALU_OR:   w_alu = w_rs1_data | w_op_b;
            ALU_XOR:  w_alu = w_rs1_data ^ w_op_b;
            ALU_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_rs1_data) < $signed(w_op_b))};
            ALU_SLTU: w_alu = {{(DATA_WIDTH-1){1'b0}}, (w_rs1_data < w_op_b)};
            default:  w_alu = w_rs1_data + w_op_b;
        endcase
    end

    // Byte offset within the word is ignored; out-of-range words read 0 and drop stores
    assign w_dmem_hit  = w_alu[DATA_WIDTH-1:2] < DMEM_LIMIT;
    assign w_mem_rdata = w_dmem_hit ? data_mem[w_alu[DA+1:2]] : '0;
    assign w_unused_ok = &{1'b0, w_alu[1:0]};

    always_ff @(posedge i_clk) begin
        if (!i_reset && i_mem_we && w_dmem_hit) data_mem[w_alu[DA+1:2]] <= w_rs2_data;
    end

    always_comb begin
        w_wb_data = w_alu;
        case (i_wb_sel)
            WB_MEM:  w_wb_data = w_mem_rdata;
            WB_PC4:  w_wb_data = w_pc_plus4;
            WB_IMM:  w_wb_data = w_imm;
            default: w_wb_data = w_alu;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
`ifdef CPU_RF_INDEX_INIT_EN
                rf[i] <= DATA_WIDTH'(i);
`else
                rf[i] <= '0;
`endif
            end
        end else if (i_reg_we && w_rd != 5'd0) begin
            rf[w_rd] <= w_wb_data;
        end
    end

    assign w_taken    = i_jal || (i_branch && ((w_rs1_data == w_rs2_data) ^ i_branch_ne));
    assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);
    assign w_pc_next  = w_taken ? r_pc + w_imm : w_pc_plus4;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_pc <= '0;
        else         r_pc <= w_pc_next;
    end

endmodule

// File: rtl/cpu_instruction_fetch.sv
// rtl/cpu_instruction_fetch.sv - byte-indexed instruction store, combinational fetch, out-of-range reads as NOP
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMEM_BYTES = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_load_en,
    input  logic [$clog2(IMEM_BYTES)-1:0] i_load_addr,
    input  logic [31:0]                   i_load_data,
    input  logic [DATA_WIDTH-1:0]         i_pc,
    output logic [31:0]                   o_instr
);
    localparam int IA = $clog2(IMEM_BYTES);

    logic [31:0] instr_mem [0:IMEM_BYTES-1];

    always_ff @(posedge i_clk) begin
        if (i_load_en) instr_mem[i_load_addr] <= i_load_data;
    end

    assign o_instr = (i_pc < DATA_WIDTH'(IMEM_BYTES)) ? instr_mem[i_pc[IA-1:0]] : 32'h0;

endmodule

// File: rtl/cpu_top.sv
// rtl/cpu_top.sv - single-cycle RV32I-subset core: control decoder plus datapath instance
module cpu_top
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_WORDS = 256
) (
    input logic i_clk,
    input logic i_reset
);
    logic [6:0] w_opcode, w_funct7;
    logic [2:0] w_funct3;
    logic       w_reg_we, w_mem_we, w_alu_src_imm, w_branch, w_branch_ne, w_jal;
    alu_op_e    w_alu_op;
    imm_type_e  w_imm_type;
    wb_sel_e    w_wb_sel;

    // Anything not matched below leaves every enable low, so it retires as a NOP
    always_comb begin
        w_reg_we      = 1'b0;
        w_mem_we      = 1'b0;
        w_alu_src_imm = 1'b0;
        w_alu_op      = ALU_ADD;
        w_imm_type    = IMM_I;
        w_wb_sel      = WB_ALU;
        w_branch      = 1'b0;
        w_branch_ne   = 1'b0;
        w_jal         = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_reg_we = 1'b1;
                case ({w_funct7, w_funct3})
                    {F7_BASE, F3_ADD}:  w_alu_op = ALU_ADD;
                    {F7_SUB,  F3_ADD}:  w_alu_op = ALU_SUB;
                    {F7_BASE, F3_AND}:  w_alu_op = ALU_AND;
                    {F7_BASE, F3_OR}:   w_alu_op = ALU_OR;
                    {F7_BASE, F3_XOR}:  w_alu_op = ALU_XOR;
                    {F7_BASE, F3_SLT}:  w_alu_op = ALU_SLT;
                    {F7_BASE, F3_SLTU}: w_alu_op = ALU_SLTU;
                    default:            w_reg_we = 1'b0;
                endcase
            end
            OP_I: begin
                w_reg_we      = 1'b1;
                w_alu_src_imm = 1'b1;
                case (w_funct3)
                    F3_ADD:  w_alu_op = ALU_ADD;
                    F3_AND:  w_alu_op = ALU_AND;
                    F3_OR:   w_alu_op = ALU_OR;
                    F3_XOR:  w_alu_op = ALU_XOR;
                    F3_SLT:  w_alu_op = ALU_SLT;
                    default: w_reg_we = 1'b0;
                endcase
            end
            OP_LOAD: if (w_funct3 == F3_LW) begin
                w_reg_we      = 1'b1;
                w_alu_src_imm = 1'b1;
                w_wb_sel      = WB_MEM;
            end
            OP_STORE: if (w_funct3 == F3_SW) begin
                w_mem_we      = 1'b1;
                w_alu_src_imm = 1'b1;
                w_imm_type    = IMM_S;
            end
            OP_BRANCH: begin
                w_imm_type  = IMM_B;
                w_branch    = (w_funct3 == F3_BEQ) || (w_funct3 == F3_BNE);
                w_branch_ne = (w_funct3 == F3_BNE);
            end
            OP_JAL: begin
                w_reg_we   = 1'b1;
                w_jal      = 1'b1;
                w_imm_type = IMM_J;
                w_wb_sel   = WB_PC4;
            end
            OP_LUI: begin
                w_reg_we   = 1'b1;
                w_imm_type = IMM_U;
                w_wb_sel   = WB_IMM;
            end
            default: ;
        endcase
    end

    data_path #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMEM_BYTES (IMEM_BYTES),
        .DMEM_WORDS (DMEM_WORDS)
    ) data_path_inst (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_reg_we      (w_reg_we),
        .i_mem_we      (w_mem_we),
        .i_alu_src_imm (w_alu_src_imm),
        .i_alu_op      (w_alu_op),
        .i_imm_type    (w_imm_type),
        .i_wb_sel      (w_wb_sel),
        .i_branch      (w_branch),
        .i_branch_ne   (w_branch_ne),
        .i_jal         (w_jal),
        .o_opcode      (w_opcode),
        .o_funct3      (w_funct3),
        .o_funct7      (w_funct7)
    );

endmodule

// File: tb/tb_cpu_top.sv
// tb/tb_cpu_top.sv - table-driven program check of cpu_top plus reset/store corner sequences
module tb_cpu_top;
    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    localparam int K_REG = 0, K_MEM = 1, K_NONE = 2;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        int          kind;
        int          idx;
        logic [31:0] exp;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    cpu_top dut (.i_clk(i_clk), .i_reset(i_reset));

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd);
        return {imm20[19:0], rd[4:0], 7'b0110111};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input int pc, input logic [31:0] ins, input int kind,
                       input int idx, input logic [31:0] exp, input int npc);
        vecs.push_back('{n, 32'(pc), ins, kind, idx, exp, 32'(npc)});
    endtask

    task automatic hold_reset_clear();
        i_reset = 1'b1;
        for (int a = 0; a < 1024; a += 4) dut.data_path_inst.instruction_fetch.instr_mem[a] = 32'h0;
        @(negedge i_clk);
    endtask

    task automatic release_reset();
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int base;
        int ri[3];
        logic [31:0] exp_rf;
        ri = '{1, 17, 31};

        // Reset state
        hold_reset_clear();
        @(negedge i_clk);
        check("reset_pc", dut.data_path_inst.r_pc, 32'h0);
        foreach (ri[k]) begin
`ifdef CPU_RF_INDEX_INIT_EN
            exp_rf = 32'(ri[k]);
`else
            exp_rf = 32'h0;
`endif
            check($sformatf("reset_x%0d", ri[k]), dut.data_path_inst.rf[ri[k]], exp_rf);
        end

        // Stores with negative offsets
        hold_reset_clear();
        base = 0;
`ifndef CPU_RF_INDEX_INIT_EN
        dut.data_path_inst.instruction_fetch.instr_mem[0]  = enc_i(30, 0, 0, 30, 7'h13);
        dut.data_path_inst.instruction_fetch.instr_mem[4]  = enc_i(20, 0, 0, 20, 7'h13);
        dut.data_path_inst.instruction_fetch.instr_mem[8]  = enc_i(10, 0, 0, 10, 7'h13);
        dut.data_path_inst.instruction_fetch.instr_mem[12] = enc_i(8, 0, 0, 8, 7'h13);
        dut.data_path_inst.instruction_fetch.instr_mem[16] = enc_i(12, 0, 0, 12, 7'h13);
        base = 20;
`endif
        dut.data_path_inst.instruction_fetch.instr_mem[base]   = enc_s(-10, 20, 30);
        dut.data_path_inst.instruction_fetch.instr_mem[base+4] = enc_s(-4, 10, 20);
        dut.data_path_inst.instruction_fetch.instr_mem[base+8] = enc_s(0, 8, 12);
        release_reset();
        repeat (base / 4 + 3) step();
        check("sw_dmem5", dut.data_path_inst.data_mem[5], 32'd20);
        check("sw_dmem4", dut.data_path_inst.data_mem[4], 32'd10);
        check("sw_dmem3", dut.data_path_inst.data_mem[3], 32'd8);

        // Main program table
        add("addi_pos",  0,   enc_i(5, 0, 0, 1, 7'h13),          K_REG, 1,  32'd5,        4);
        add("addi_neg",  4,   enc_i(-3, 0, 0, 2, 7'h13),         K_REG, 2,  32'hFFFFFFFD, 8);
        add("add",       8,   enc_r(0, 2, 1, 0, 3),              K_REG, 3,  32'd2,        12);
        add("sub",       12,  enc_r(32, 1, 2, 0, 4),             K_REG, 4,  32'hFFFFFFF8, 16);
        add("x0_write",  16,  enc_i(7, 0, 0, 0, 7'h13),          K_REG, 0,  32'h0,        20);
        add("add_x0",    20,  enc_r(0, 0, 0, 0, 5),              K_REG, 5,  32'h0,        24);
        add("slt",       24,  enc_r(0, 1, 2, 2, 6),              K_REG, 6,  32'd1,        28);
        add("sltu",      28,  enc_r(0, 1, 2, 3, 7),              K_REG, 7,  32'd0,        32);
        add("slti",      32,  enc_i(-2, 2, 2, 8, 7'h13),         K_REG, 8,  32'd1,        36);
        add("xori",      36,  enc_i(255, 1, 4, 9, 7'h13),        K_REG, 9,  32'hFA,       40);
        add("ori",       40,  enc_i(-16, 1, 6, 10, 7'h13),       K_REG, 10, 32'hFFFFFFF5, 44);
        add("andi",      44,  enc_i(15, 2, 7, 11, 7'h13),        K_REG, 11, 32'hD,        48);
        add("lui",       48,  enc_u(20'hDEADC, 12),              K_REG, 12, 32'hDEADC000, 52);
        add("addi_lo",   52,  enc_i(-273, 12, 0, 12, 7'h13),     K_REG, 12, 32'hDEADBEEF, 56);
        add("sw",        56,  enc_s(8, 12, 0),                   K_MEM, 2,  32'hDEADBEEF, 60);
        add("lw",        60,  enc_i(8, 0, 2, 13, 7'h03),         K_REG, 13, 32'hDEADBEEF, 64);
        add("sw_oob",    64,  enc_s(1024, 12, 0),                K_MEM, 0,  32'h0,        68);
        add("lw_oob",    68,  enc_i(1024, 0, 2, 13, 7'h03),      K_REG, 13, 32'h0,        72);
        add("and",       72,  enc_r(0, 2, 12, 7, 14),            K_REG, 14, 32'hDEADBEED, 76);
        add("or",        76,  enc_r(0, 11, 1, 6, 15),            K_REG, 15, 32'hD,        80);
        add("xor",       80,  enc_r(0, 2, 1, 4, 16),             K_REG, 16, 32'hFFFFFFF8, 84);
        add("lw_unal",   84,  enc_i(11, 0, 2, 17, 7'h03),        K_REG, 17, 32'hDEADBEEF, 88);
        add("illegal",   88,  32'hFFFFFFFF,                      K_REG, 1,  32'd5,        92);
        add("beq_t",     92,  enc_b(8, 1, 1, 0),                 K_NONE, 0, 32'h0,        100);
        add("bne_nt",    100, enc_b(8, 1, 1, 1),                 K_NONE, 0, 32'h0,        104);
        add("bne_t",     104, enc_b(8, 2, 1, 1),                 K_NONE, 0, 32'h0,        112);
        add("beq_nt",    112, enc_b(8, 2, 1, 0),                 K_NONE, 0, 32'h0,        116);
        add("jal",       116, enc_j(12, 18),                     K_REG, 18, 32'd120,      128);
        add("bne_back",  128, enc_b(-8, 2, 1, 1),                K_NONE, 0, 32'h0,        120);
        add("jal_x0",    120, enc_j(16, 0),                      K_REG, 0,  32'h0,        136);
        add("nop_zero",  136, 32'h0,                             K_REG, 18, 32'd120,      140);

        hold_reset_clear();
        foreach (vecs[v]) dut.data_path_inst.instruction_fetch.instr_mem[vecs[v].pc] = vecs[v].instr;
        release_reset();
        foreach (vecs[v]) begin
            step();
            check({vecs[v].name, "_pc"}, dut.data_path_inst.r_pc, vecs[v].exp_pc);
            if (vecs[v].kind == K_REG)
                check(vecs[v].name, dut.data_path_inst.rf[vecs[v].idx], vecs[v].exp);
            else if (vecs[v].kind == K_MEM)
                check(vecs[v].name, dut.data_path_inst.data_mem[vecs[v].idx], vecs[v].exp);
        end

        // Asynchronous reset mid-cycle at PC 12
        hold_reset_clear();
        dut.data_path_inst.instruction_fetch.instr_mem[0]  = enc_i(1, 0, 0, 20, 7'h13);
        dut.data_path_inst.instruction_fetch.instr_mem[4]  = enc_i(1, 20, 0, 20, 7'h13);
        dut.data_path_inst.instruction_fetch.instr_mem[8]  = enc_i(1, 20, 0, 20, 7'h13);
        dut.data_path_inst.instruction_fetch.instr_mem[12] = enc_i(99, 0, 0, 21, 7'h13);
        release_reset();
        repeat (3) step();
        check("ar_pc12", dut.data_path_inst.r_pc, 32'd12);
        check("ar_x20_pre", dut.data_path_inst.rf[20], 32'd3);
        #2;
        i_reset = 1'b1;
        #1;
        check("ar_pc0_async", dut.data_path_inst.r_pc, 32'h0);
`ifdef CPU_RF_INDEX_INIT_EN
        check("ar_x21_async", dut.data_path_inst.rf[21], 32'd21);
`else
        check("ar_x21_async", dut.data_path_inst.rf[21], 32'h0);
`endif
        step();
        check("ar_pc_held", dut.data_path_inst.r_pc, 32'h0);
        check("ar_dmem_kept", dut.data_path_inst.data_mem[2], 32'hDEADBEEF);
        release_reset();
        step();
        check("ar_first_pc", dut.data_path_inst.r_pc, 32'd4);
        check("ar_first_x20", dut.data_path_inst.rf[20], 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_top.md
CPU_TOP -- requirements
Module: cpu_top

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, datapath/register/ALU width; only 32 supported.
REQ-002 Parameter: IMEM_BYTES, default 1024, instruction memory size in bytes.
REQ-003 Parameter: DMEM_WORDS, default 256, data memory depth in 32-bit words.
REQ-004 Port: i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: i_reset  input  1  reset, asynchronous, active-high.
REQ-006 No other ports; state is observed hierarchically.

Function
REQ-007 Single-cycle RV32I subset: one instruction fetched, decoded, executed and retired per i_clk cycle after reset.
REQ-008 Supported: ADD, SUB, AND, OR, XOR, SLT, SLTU, ADDI, ANDI, ORI, XORI, SLTI, LW, SW, BEQ, BNE, JAL, LUI.
REQ-009 Any other encoding, including 32'h0, executes as NOP: PC+4, no register or memory write.
REQ-010 PC: DATA_WIDTH register; next PC = PC+imm for taken branch or JAL, else PC+4; wraps modulo 2^32.
REQ-011 Instruction memory instr_mem is indexed directly by byte address PC; entries written only at word-aligned indices (0, 4, 8, ...); read combinational.
REQ-012 PC >= IMEM_BYTES fetches 32'h0, i.e. NOP.
REQ-013 Register file: 32 x DATA_WIDTH; two combinational read ports; one write port at rising edge; x0 reads 0 and ignores writes.
REQ-014 Immediates sign-extended per I/S/B/J formats; LUI places imm[31:12] with zero low 12 bits.
REQ-015 LW/SW effective address = rs1 + sign-extended imm, computed in 32-bit two's complement (e.g. 30 + -10 = 20).
REQ-016 Data memory: word-addressed by address[..:2]; address[1:0] ignored; SW writes rs2 at rising edge; LW reads combinationally, writeback at same edge.
REQ-017 Data addresses beyond DMEM_WORDS: SW ignored, LW returns 0.
REQ-018 SLT signed compare, SLTU unsigned compare; result is 1 or 0.
REQ-019 Reading a register in the cycle after its write returns the new value.

Reset
REQ-020 i_reset asserted: PC = 0 immediately (asynchronous); register file cleared per REQ-023; data memory contents retained; instr_mem untouched.
REQ-021 Reset mid-execution aborts the current instruction with no write; the first instruction after deassertion is at address 0.
REQ-022 While i_reset is high, no register or memory writes occur.

Configuration
REQ-023 Macro CPU_RF_INDEX_INIT_EN: defined -> reset loads x[i] = i for i = 1..31 (test preload); undefined -> reset loads all registers to 0.

Structure
REQ-024 Shared package cpu_pkg: opcode/funct3/funct7 constants, ALU-operation enum, immediate-type enum.
REQ-025 One sub-module data_path, instance data_path_inst, containing PC, fetch (instance instruction_fetch holding array instr_mem), register file, ALU, data memory; cpu_top holds only the instance and control decoder.

Verification
REQ-026 CPU_RF_INDEX_INIT_EN set; instr_mem[0]=SW x20,-10(x30), [4]=SW x10,-4(x20), [8]=SW x8,0(x12); release reset -> after 3 cycles dmem word 5 = 20, word 4 = 10, word 3 = 8.
REQ-027 ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1 -> x3 = 2, x4 = 32'hFFFFFFF8.
REQ-028 ADDI x0,x0,7 then ADD x5,x0,x0 -> x0 = 0, x5 = 0.
REQ-029 SW x1,8(x0) with x1 = 0xDEADBEEF, then LW x6,8(x0) -> x6 = 0xDEADBEEF on next cycle.
REQ-030 BEQ x1,x1,+8 at PC 0 -> next PC = 8; BNE x1,x1,+8 -> next PC = 4; JAL x1,+12 at PC 4 -> x1 = 8, PC = 16.
REQ-031 Assert i_reset asynchronously mid-cycle at PC = 12 -> PC = 0 before the next edge; no write from the aborted instruction.
